s2p: RTL and testbench

Serial-to-parallel converter: the receiving end of the LSB-first serial valid/ready link driven by the `p2s` block. It assembles N serial bits into an N-bit word and presents it on a parallel valid/ready port. A one-word output register lets assembly of the next word overlap with a stalled parallel consumer. Sits between a serial link and a parallel datapath; `p2s` → `s2p` loopback returns the original word.

---
 rtl/s2p.sv | 73 +++++++
 tb/tb_s2p.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2p.sv
// Serial-to-parallel converter: assembles N LSB-first serial bits into a word
// and presents it on a parallel valid/ready port through a one-word output register.
module s2p #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  input  logic         s_data,
  output logic         s_ready,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  input  logic         p_ready
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]  sh_q, sh_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  p_data_q, p_data_d;
  logic          p_valid_q, p_valid_d;

  logic          at_last;
  logic          accept;
  logic          final_bit;
  logic [N-1:0]  sh_next;

  assign at_last   = (count_q == LAST);
  // Only the word-completing bit can stall; partial-word bits always fit in sh.
  assign s_ready   = !(at_last && p_valid_q && !p_ready);
  assign accept    = s_valid && s_ready;
  assign final_bit = accept && at_last;
  assign sh_next   = {s_data, sh_q[N-1:1]};

  always_comb begin
    sh_d      = sh_q;
    count_d   = count_q;
    p_data_d  = p_data_q;
    p_valid_d = p_valid_q;

    if (accept) begin
      sh_d    = sh_next;
      count_d = at_last ? '0 : count_q + CW'(1);
    end

    // A final bit arriving in the same cycle as a consume reloads without a bubble.
    if (final_bit) begin
      p_data_d  = sh_next;
      p_valid_d = 1'b1;
    end else if (p_ready) begin
      p_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh_q      <= '0;
      count_q   <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      count_q   <= count_d;
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign p_data  = p_data_q;
  assign p_valid = p_valid_q;

endmodule

// File: tb/tb_s2p.sv
// Self-checking bench for s2p: directed cycle-level sequences, a table of words
// with random consumer stalls, and a random N=5 stream, all scored via queues.
module tb_s2p;

  logic       clk = 1'b0;
  logic       rstn;
  logic       s_valid8, s_data8, p_ready8;
  logic       s_ready8, p_valid8;
  logic [7:0] p_data8;
  logic       s_valid5, s_data5, p_ready5;
  logic       s_ready5, p_valid5;
  logic [4:0] p_data5;

  always #5 clk = ~clk;

  s2p #(.N(8)) dut8 (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid8), .s_data(s_data8), .s_ready(s_ready8),
    .p_data(p_data8), .p_valid(p_valid8), .p_ready(p_ready8)
  );

  s2p #(.N(5)) dut5 (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid5), .s_data(s_data5), .s_ready(s_ready5),
    .p_data(p_data5), .p_valid(p_valid5), .p_ready(p_ready5)
  );

  typedef struct {
    logic [7:0] word;
    int         gap_max;
    bit         rnd_rdy;
    logic [7:0] exp_word;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_rx8    = 0;
  int         n_rx5    = 0;
  logic [7:0] q8[$];
  logic [4:0] q5[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Handshakes are scored at the falling edge, where inputs and outputs are settled.
  task automatic monitor();
    if (rstn && p_valid8 && p_ready8) begin
      if (q8.size() == 0) begin
        n_checks++;
        $display("FAIL rx8_unexpected: got %0h, want no word", p_data8);
      end else begin
        check("rx8_word", {24'd0, p_data8}, {24'd0, q8.pop_front()});
      end
      n_rx8++;
    end
    if (rstn && p_valid5 && p_ready5) begin
      if (q5.size() == 0) begin
        n_checks++;
        $display("FAIL rx5_unexpected: got %0h, want no word", p_data5);
      end else begin
        check("rx5_word", {27'd0, p_data5}, {27'd0, q5.pop_front()});
      end
      n_rx5++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; leaves s_valid high so bits can run gapless.
  task automatic drive8(input logic b, input int gap_max, input bit rnd, input bit exp_rdy);
    int gap;
    int budget;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin
      s_valid8 = 1'b0;
      s_data8  = 1'($urandom);
      if (rnd) p_ready8 = 1'($urandom);
      tick();
    end
    s_valid8 = 1'b1;
    s_data8  = b;
    if (rnd) p_ready8 = 1'($urandom);
    #1;
    if (exp_rdy) check("s_ready8_bit", {31'd0, s_ready8}, 32'd1);
    budget = 100;
    while (!s_ready8 && budget > 0) begin
      tick();
      if (rnd) p_ready8 = 1'($urandom);
      #1;
      budget--;
    end
    if (budget == 0) check("s_ready8_timeout", {31'd0, s_ready8}, 32'd1);
    tick();
  endtask

  task automatic drive5(input logic b);
    int budget;
    s_valid5 = 1'b1;
    s_data5  = b;
    p_ready5 = 1'($urandom);
    #1;
    budget = 100;
    while (!s_ready5 && budget > 0) begin
      tick();
      p_ready5 = 1'($urandom);
      #1;
      budget--;
    end
    if (budget == 0) check("s_ready5_timeout", {31'd0, s_ready5}, 32'd1);
    tick();
  endtask

  task automatic send8(input logic [7:0] w, input int gap_max, input bit rnd, input bit exp_rdy);
    for (int i = 0; i < 8; i++) drive8(w[i], gap_max, rnd, exp_rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl[8];
    logic [7:0] bb;
    logic [7:0] w3c;
    logic [4:0] w5;
    int         rx_before;

    tbl[0] = '{word: 8'hA5, gap_max: 0, rnd_rdy: 1'b0, exp_word: 8'hA5};
    tbl[1] = '{word: 8'hFF, gap_max: 0, rnd_rdy: 1'b0, exp_word: 8'hFF};
    tbl[2] = '{word: 8'h00, gap_max: 1, rnd_rdy: 1'b0, exp_word: 8'h00};
    tbl[3] = '{word: 8'h01, gap_max: 0, rnd_rdy: 1'b1, exp_word: 8'h01};
    tbl[4] = '{word: 8'h80, gap_max: 2, rnd_rdy: 1'b1, exp_word: 8'h80};
    tbl[5] = '{word: 8'h5A, gap_max: 0, rnd_rdy: 1'b1, exp_word: 8'h5A};
    tbl[6] = '{word: 8'hC3, gap_max: 3, rnd_rdy: 1'b1, exp_word: 8'hC3};
    tbl[7] = '{word: 8'h7E, gap_max: 0, rnd_rdy: 1'b1, exp_word: 8'h7E};

    rstn = 1'b0;
    s_valid8 = 1'b0; s_data8 = 1'b0; p_ready8 = 1'b0;
    s_valid5 = 1'b0; s_data5 = 1'b0; p_ready5 = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
    check("reset_p_valid", {31'd0, p_valid8}, 32'd0);
    check("reset_p_data", {24'd0, p_data8}, 32'd0);
    check("reset_s_ready", {31'd0, s_ready8}, 32'd1);

    // Single word with the consumer always ready.
    p_ready8 = 1'b1;
    q8.push_back(8'hA5);
    send8(8'hA5, 0, 1'b0, 1'b1);
    s_valid8 = 1'b0;
    check("single_p_valid", {31'd0, p_valid8}, 32'd1);
    check("single_p_data", {24'd0, p_data8}, 32'hA5);
    tick();
    check("single_pulse_end", {31'd0, p_valid8}, 32'd0);

    // Back-to-back words with no idle cycle between them.
    q8.push_back(8'hA5);
    q8.push_back(8'h3C);
    for (int i = 0; i < 16; i++) begin
      bb = (i < 8) ? 8'hA5 : 8'h3C;
      drive8(bb[i % 8], 0, 1'b0, 1'b1);
      if (i == 7) check("b2b_first_data", {24'd0, p_data8}, 32'hA5);
      if (i == 8) check("b2b_gap_valid", {31'd0, p_valid8}, 32'd0);
      if (i == 15) begin
        check("b2b_second_valid", {31'd0, p_valid8}, 32'd1);
        check("b2b_second_data", {24'd0, p_data8}, 32'h3C);
      end
    end
    s_valid8 = 1'b0;
    tick();

    // Backpressure: final bit of 3C stalls until the held A5 is taken.
    p_ready8 = 1'b0;
    w3c = 8'h3C;
    q8.push_back(8'hA5);
    q8.push_back(8'h3C);
    send8(8'hA5, 0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive8(w3c[i], 0, 1'b0, 1'b1);
    check("bp_hold_data", {24'd0, p_data8}, 32'hA5);
    s_valid8 = 1'b1;
    s_data8  = w3c[7];
    #1;
    check("bp_s_ready_low", {31'd0, s_ready8}, 32'd0);
    tick();
    #1;
    check("bp_still_low", {31'd0, s_ready8}, 32'd0);
    check("bp_still_valid", {31'd0, p_valid8}, 32'd1);
    check("bp_still_data", {24'd0, p_data8}, 32'hA5);
    p_ready8 = 1'b1;
    #1;
    check("bp_s_ready_comb", {31'd0, s_ready8}, 32'd1);
    tick();
    s_valid8 = 1'b0;
    check("bp_reload_valid", {31'd0, p_valid8}, 32'd1);
    check("bp_reload_data", {24'd0, p_data8}, 32'h3C);
    tick();
    check("bp_drained", {31'd0, p_valid8}, 32'd0);

    // Gapped input with garbage on s_data during idle cycles.
    rx_before = n_rx8;
    q8.push_back(8'hA5);
    send8(8'hA5, 5, 1'b0, 1'b1);
    s_valid8 = 1'b0;
    repeat (3) tick();
    check("gap_once", n_rx8 - rx_before, 32'd1);

    // Reset part-way through a word of ones.
    for (int i = 0; i < 5; i++) drive8(1'b1, 0, 1'b0, 1'b1);
    s_valid8 = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, p_valid8}, 32'd0);
    check("rst_mid_data", {24'd0, p_data8}, 32'd0);
    q8.push_back(8'h3C);
    send8(8'h3C, 0, 1'b0, 1'b1);
    s_valid8 = 1'b0;
    check("rst_mid_next", {24'd0, p_data8}, 32'h3C);
    tick();

    // Table of words, some under random consumer stalls.
    for (int v = 0; v < 8; v++) begin
      if (!tbl[v].rnd_rdy) p_ready8 = 1'b1;
      q8.push_back(tbl[v].exp_word);
      send8(tbl[v].word, tbl[v].gap_max, tbl[v].rnd_rdy, 1'b0);
    end
    s_valid8 = 1'b0;
    p_ready8 = 1'b1;
    repeat (4) tick();
    check("tbl_queue_empty", q8.size(), 32'd0);

    // N=5 random stream with random stalls.
    rx_before = n_rx5;
    for (int k = 0; k < 20; k++) begin
      w5 = 5'($urandom_range(0, 31));
      q5.push_back(w5);
      for (int i = 0; i < 5; i++) drive5(w5[i]);
    end
    s_valid5 = 1'b0;
    p_ready5 = 1'b1;
    repeat (4) tick();
    check("n5_queue_empty", q5.size(), 32'd0);
    check("n5_count", n_rx5 - rx_before, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
